expander_poll_seq: RTL and testbench
====================================

EXPANDER_POLL_SEQ -- requirements
Module: expander_poll_seq

Interface
REQ-001 Parameter NUM_CH, default 2, number of expander channels (1..8).
REQ-002 Parameter RELAX_TIME, default 1500, clk_50 cycles idle between operations.
REQ-003 Parameter BLINK_PERIOD, default 2000, clk_50 cycles per sweep wait; LED phase toggles at half.
REQ-004 Parameter TIMEOUT, default 100000, max cycles an operation may wait for completion.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low. Ports below, clock and reset first.
REQ-006 clk_50  in  1  system clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 enable  in  1  permits new sweeps.
REQ-009 ch_en  in  NUM_CH  per-channel include mask.
REQ-010 led_mode  in  2*NUM_CH  per-channel LED mode: 00 off, 01 green, 10 blink, 11 auto.
REQ-011 dev_ready  in  NUM_CH  per-channel driver ready.
REQ-012 sfp_txflt, sfp_prsn  in  NUM_CH each  expander input bits (prsn low = module present).
REQ-013 need_write_reg_o, need_read_reg_i, need_read_reg_o  out  NUM_CH each  request pulses.
REQ-014 sfp_gled, sfp_rled  out  NUM_CH each  LED bits to expander outputs.
REQ-015 timeout_err  out  NUM_CH  sticky per-channel timeout flag.
REQ-016 cur_ch  out  $clog2(NUM_CH) (min 1)  channel being served.
REQ-017 sweep_done  out  1  one-cycle pulse at end of each sweep.

Function
REQ-018 FSM states: IDLE, WAIT_TIMER, WRITE_O, RELAX_1, READ_I, RELAX_2, READ_O, NEXT_CH.
REQ-019 IDLE -> WAIT_TIMER when enable=1 and ch_en nonzero; cur_ch loads lowest enabled channel.
REQ-020 WAIT_TIMER counts 0..BLINK_PERIOD; -> WRITE_O when count==BLINK_PERIOD and dev_ready[cur_ch]=1.
REQ-021 Global blink phase toggles when WAIT_TIMER count==BLINK_PERIOD/2.
REQ-022 On each op state entry (WRITE_O, READ_I, READ_O) the matching need_* bit for cur_ch SHALL be high exactly one cycle, the cycle after entry; all other need_* bits low.
REQ-023 Op completes on rising edge of dev_ready[cur_ch] (low previous cycle, high now): WRITE_O->RELAX_1, READ_I->RELAX_2, READ_O->NEXT_CH.
REQ-024 RELAX_x counts from 0 on entry; exits when count==RELAX_TIME and dev_ready[cur_ch]=1.
REQ-025 Op timer restarts on each op entry; if it reaches TIMEOUT without completion: set timeout_err[cur_ch], go NEXT_CH.
REQ-026 Completion and timeout in the same cycle: completion wins, no error.
REQ-027 NEXT_CH: advance cur_ch to next higher enabled channel -> WRITE_O; if none, pulse sweep_done, -> IDLE.
REQ-028 ch_en sampled at IDLE exit and at NEXT_CH; changes mid-operation do not abort the current op.
REQ-029 enable=0 mid-sweep: current sweep completes; no new sweep starts.
REQ-030 timeout_err bits clear only on reset.
REQ-031 All counters width 32, unsigned; no wrap possible since each is cleared on state exit.
REQ-032 LED outputs registered, one cycle latency: 00 -> g=0,r=0; 01 -> g=1,r=0; 10 -> g=phase,r=~phase; 11 -> prsn=1: g=0,r=0; txflt=1: g=0,r=1; else g=phase,r=0.

Reset
REQ-033 During rst_n=0: state IDLE, cur_ch=0, all counters 0, phase 1, all need_*, sfp_gled, sfp_rled, timeout_err, sweep_done = 0.
REQ-034 Reset asserted mid-operation SHALL abort immediately; no request pulse issued until a new sweep after release.

Structure
REQ-035 Package expander_pkg SHALL hold the state enum, the LED mode enum and default parameter constants.
REQ-036 Sub-module expander_led_drv SHALL implement REQ-032 per channel, instantiated NUM_CH times by generate.

Verification (NUM_CH=2, RELAX_TIME=10, BLINK_PERIOD=20, TIMEOUT=50)
REQ-037 ch_en=11, ready drops 3 cycles after each request -> pulse order wr_o[0], rd_i[0], rd_o[0], wr_o[1], rd_i[1], rd_o[1], then one sweep_done; relax gaps >= 10 cycles.
REQ-038 ch_en=10 -> only channel 1 requests; cur_ch=1 throughout sweep.
REQ-039 dev_ready[1] stuck low after wr_o[1] -> timeout_err=10 after 50 cycles, FSM to NEXT_CH, sweep_done, next sweep still serves ch0.
REQ-040 led_mode=11 for ch0, prsn[0]=0, txflt[0]=1 -> rled[0]=1, gled[0]=0; txflt[0]=0 -> gled[0] follows phase, toggling once per sweep.
REQ-041 rst_n low during READ_I of ch0 -> all outputs 0 next cycle; after release, first request is wr_o[0] following a full 20-cycle WAIT_TIMER.
REQ-042 Ready rising edge in the same cycle the op timer hits 50 -> no timeout_err, normal transition.

Source files
------------

// File: rtl/expander_pkg.sv
// Shared types and default timing constants for the SFP expander poll sequencer.
package expander_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TIMER,
    WRITE_O,
    RELAX_1,
    READ_I,
    RELAX_2,
    READ_O,
    NEXT_CH
  } state_t;

  typedef enum logic [1:0] {
    LED_OFF   = 2'b00,
    LED_GREEN = 2'b01,
    LED_BLINK = 2'b10,
    LED_AUTO  = 2'b11
  } led_mode_t;

  localparam int DEF_NUM_CH       = 2;
  localparam int DEF_RELAX_TIME   = 1500;
  localparam int DEF_BLINK_PERIOD = 2000;
  localparam int DEF_TIMEOUT      = 100000;

endpackage

// File: rtl/expander_led_drv.sv
// Per-channel LED encoder: maps mode, blink phase and module status to registered green/red bits.
module expander_led_drv
  import expander_pkg::*;
(
  input  logic       clk_50,
  input  logic       rst_n,
  input  logic [1:0] mode,
  input  logic       phase,
  input  logic       prsn,
  input  logic       txflt,
  output logic       gled,
  output logic       rled
);

  logic g_d, r_d;

  always_comb begin
    g_d = 1'b0;
    r_d = 1'b0;
    case (led_mode_t'(mode))
      LED_GREEN: g_d = 1'b1;
      LED_BLINK: begin
        g_d = phase;
        r_d = ~phase;
      end
      LED_AUTO: begin
        // prsn high means no module fitted: keep both LEDs dark
        if (!prsn) begin
          if (txflt) r_d = 1'b1;
          else       g_d = phase;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      gled <= 1'b0;
      rled <= 1'b0;
    end else begin
      gled <= g_d;
      rled <= r_d;
    end
  end

endmodule

// File: rtl/expander_poll_seq.sv
// Sweeps enabled expander channels: write outputs, read inputs, read outputs per channel,
// with relax gaps, per-op timeouts and a shared LED blink phase advanced once per sweep.
//
// state      | meaning
// IDLE       | waiting for enable and a nonzero channel mask
// WAIT_TIMER | blink/sweep wait; phase toggles at the halfway count
// WRITE_O    | output-register write requested, waiting for ready rise
// RELAX_1    | idle gap after the write
// READ_I     | input-register read requested, waiting for ready rise
// RELAX_2    | idle gap after the input read
// READ_O     | output-register read requested, waiting for ready rise
// NEXT_CH    | pick next higher enabled channel or finish the sweep
module expander_poll_seq
  import expander_pkg::*;
#(
  parameter int  NUM_CH       = DEF_NUM_CH,
  parameter int  RELAX_TIME   = DEF_RELAX_TIME,
  parameter int  BLINK_PERIOD = DEF_BLINK_PERIOD,
  parameter int  TIMEOUT      = DEF_TIMEOUT,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk_50,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [NUM_CH-1:0]   ch_en,
  input  logic [2*NUM_CH-1:0] led_mode,
  input  logic [NUM_CH-1:0]   dev_ready,
  input  logic [NUM_CH-1:0]   sfp_txflt,
  input  logic [NUM_CH-1:0]   sfp_prsn,
  output logic [NUM_CH-1:0]   need_write_reg_o,
  output logic [NUM_CH-1:0]   need_read_reg_i,
  output logic [NUM_CH-1:0]   need_read_reg_o,
  output logic [NUM_CH-1:0]   sfp_gled,
  output logic [NUM_CH-1:0]   sfp_rled,
  output logic [NUM_CH-1:0]   timeout_err,
  output logic [CH_W-1:0]     cur_ch,
  output logic                sweep_done
);

  localparam int          CH_P        = 2 ** CH_W;
  localparam logic [31:0] BLINK_END   = 32'(BLINK_PERIOD);
  localparam logic [31:0] BLINK_HALF  = 32'(BLINK_PERIOD / 2);
  localparam logic [31:0] RELAX_END   = 32'(RELAX_TIME);
  localparam logic [31:0] TIMEOUT_END = 32'(TIMEOUT);

  state_t            state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [CH_W-1:0]   cur_ch_d, first_ch, next_ch;
  logic              first_vld, next_vld;
  logic              phase_q, phase_d;
  logic [NUM_CH-1:0] err_d, sel_q, sel_d;
  logic [CH_P-1:0]   rdy_now, rdy_prev;
  logic              rdy_cur, rdy_rise, done_d;

  // padded so a channel index never addresses past the ready vector
  assign rdy_now  = CH_P'(dev_ready);
  assign rdy_cur  = rdy_now[cur_ch];
  assign rdy_rise = rdy_cur & ~rdy_prev[cur_ch];
  assign sel_q    = NUM_CH'(1) << cur_ch;
  assign sel_d    = NUM_CH'(1) << cur_ch_d;

  always_comb begin
    first_ch  = '0;
    first_vld = 1'b0;
    next_ch   = '0;
    next_vld  = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_en[i]) begin
        first_ch  = CH_W'(i);
        first_vld = 1'b1;
      end
      if (ch_en[i] && (i > int'(cur_ch))) begin
        next_ch  = CH_W'(i);
        next_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cur_ch_d = cur_ch;
    phase_d  = phase_q;
    err_d    = timeout_err;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && first_vld) begin
          state_d  = WAIT_TIMER;
          cur_ch_d = first_ch;
          cnt_d    = '0;
        end
      end
      WAIT_TIMER: begin
        if (cnt_q == BLINK_HALF) phase_d = ~phase_q;
        if ((cnt_q == BLINK_END) && rdy_cur) begin
          state_d = WRITE_O;
          cnt_d   = '0;
        end else if (cnt_q < BLINK_END) begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      WRITE_O, READ_I, READ_O: begin
        // completion is checked first so a ready rise on the timeout count still succeeds
        if (rdy_rise) begin
          cnt_d = '0;
          if (state_q == WRITE_O)     state_d = RELAX_1;
          else if (state_q == READ_I) state_d = RELAX_2;
          else                        state_d = NEXT_CH;
        end else if (cnt_q == TIMEOUT_END) begin
          err_d   = timeout_err | sel_q;
          state_d = NEXT_CH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RELAX_1, RELAX_2: begin
        if ((cnt_q == RELAX_END) && rdy_cur) begin
          state_d = (state_q == RELAX_1) ? READ_I : READ_O;
          cnt_d   = '0;
        end else if (cnt_q < RELAX_END) begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      NEXT_CH: begin
        cnt_d = '0;
        if (next_vld) begin
          cur_ch_d = next_ch;
          state_d  = WRITE_O;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      cur_ch           <= '0;
      phase_q          <= 1'b1;
      timeout_err      <= '0;
      rdy_prev         <= '0;
      sweep_done       <= 1'b0;
      need_write_reg_o <= '0;
      need_read_reg_i  <= '0;
      need_read_reg_o  <= '0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      cur_ch           <= cur_ch_d;
      phase_q          <= phase_d;
      timeout_err      <= err_d;
      rdy_prev         <= rdy_now;
      sweep_done       <= done_d;
      need_write_reg_o <= (state_d == WRITE_O && state_q != WRITE_O) ? sel_d : '0;
      need_read_reg_i  <= (state_d == READ_I  && state_q != READ_I)  ? sel_d : '0;
      need_read_reg_o  <= (state_d == READ_O  && state_q != READ_O)  ? sel_d : '0;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_led
    expander_led_drv u_led (
      .clk_50 (clk_50),
      .rst_n  (rst_n),
      .mode   (led_mode[2*g +: 2]),
      .phase  (phase_q),
      .prsn   (sfp_prsn[g]),
      .txflt  (sfp_txflt[g]),
      .gled   (sfp_gled[g]),
      .rled   (sfp_rled[g])
    );
  end

endmodule

// File: tb/tb_expander_poll_seq.sv
// Bench for expander_poll_seq: a ready-responder emulates the drivers and sweeps are
// checked against an event-order model built from the channel mask and response delays.
module tb_expander_poll_seq;

  localparam int RT = 10;
  localparam int BP = 20;
  localparam int TO = 50;

  logic       clk_50 = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] ch_en = '0;
  logic [3:0] led_mode = '0;
  logic [1:0] dev_ready = '1;
  logic [1:0] sfp_txflt = '0;
  logic [1:0] sfp_prsn = '1;
  logic [1:0] need_write_reg_o, need_read_reg_i, need_read_reg_o;
  logic [1:0] sfp_gled, sfp_rled, timeout_err;
  logic       cur_ch, sweep_done;

  int vectors = 0;
  int errors = 0;

  always #10 clk_50 = ~clk_50;

  expander_poll_seq #(.NUM_CH(2), .RELAX_TIME(RT), .BLINK_PERIOD(BP), .TIMEOUT(TO)) dut (
    .clk_50(clk_50), .rst_n(rst_n), .enable(enable), .ch_en(ch_en), .led_mode(led_mode),
    .dev_ready(dev_ready), .sfp_txflt(sfp_txflt), .sfp_prsn(sfp_prsn),
    .need_write_reg_o(need_write_reg_o), .need_read_reg_i(need_read_reg_i),
    .need_read_reg_o(need_read_reg_o), .sfp_gled(sfp_gled), .sfp_rled(sfp_rled),
    .timeout_err(timeout_err), .cur_ch(cur_ch), .sweep_done(sweep_done)
  );

  // event code = kind*2 + channel, kind 0 write_o, 1 read_i, 2 read_o
  int         cyc = 0;
  int         ev_code[$], ev_cyc[$], ev_cur[$], exp_code[$];
  logic [1:0] exp_err;
  int         dly[2][3];
  int         rsp_left[2];
  int         done_cnt = 0, err_cyc = -1, sweep_start = 0;
  logic [1:0] prev_err = '0;
  logic [5:0] prev_need = '0;
  bit         model_phase = 1'b1;

  task automatic tick();
    logic [5:0] nv;
    @(posedge clk_50);
    #1;
    cyc++;
    nv = {need_read_reg_o, need_read_reg_i, need_write_reg_o};
    vectors++;
    if ($countones(nv) > 1 || (nv & prev_need) != 6'd0) begin
      errors++;
      $display("FAIL need_pulse cyc=%0d got=%b prev=%b required one-hot single-cycle", cyc, nv, prev_need);
    end
    prev_need = nv;
    if (sweep_done) done_cnt++;
    if (timeout_err != prev_err) err_cyc = cyc;
    prev_err = timeout_err;
    for (int c = 0; c < 2; c++)
      if (rsp_left[c] > 0) begin
        rsp_left[c]--;
        if (rsp_left[c] == 0) dev_ready[c] = 1'b1;
      end
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < 2; c++)
        if (nv[k*2+c]) begin
          ev_code.push_back(k*2+c);
          ev_cyc.push_back(cyc);
          ev_cur.push_back(int'(cur_ch));
          dev_ready[c] = 1'b0;
          rsp_left[c]  = dly[c][k];
        end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    ch_en = '0;
    dev_ready = '1;
    rsp_left[0] = 0;
    rsp_left[1] = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    model_phase = 1'b1;
    prev_err = '0;
    err_cyc = -1;
    tick();
  endtask

  // Spec model: channels ascending, three ops each; an op whose ready rise comes later
  // than TIMEOUT cycles (or never) flags that channel and skips its remaining ops.
  task automatic build_exp(input logic [1:0] mask);
    exp_code.delete();
    exp_err = '0;
    for (int c = 0; c < 2; c++)
      if (mask[c])
        for (int k = 0; k < 3; k++) begin
          exp_code.push_back(k*2+c);
          if (dly[c][k] < 0 || dly[c][k] > TO) begin
            exp_err[c] = 1'b1;
            break;
          end
        end
  endtask

  task automatic set_dly(input int d);
    for (int c = 0; c < 2; c++)
      for (int k = 0; k < 3; k++) dly[c][k] = d;
  endtask

  task automatic run_sweep(input logic [1:0] mask);
    ev_code.delete();
    ev_cyc.delete();
    ev_cur.delete();
    done_cnt = 0;
    ch_en = mask;
    enable = 1'b1;
    sweep_start = cyc;
    while (done_cnt == 0 && cyc - sweep_start < 3000) begin
      tick();
      if (ev_code.size() > 0) enable = 1'b0;
    end
    enable = 1'b0;
    vectors++;
    if (done_cnt == 0) begin
      errors++;
      $display("FAIL sweep_done_wait got=none required=pulse within 3000 cycles");
    end else begin
      model_phase = ~model_phase;
    end
    repeat (BP + 10) tick();
    vectors++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL sweep_done_count got=%0d required=1", done_cnt);
    end
  endtask

  function automatic logic [1:0] led_exp(input logic [1:0] m, input bit ph, input logic p, input logic t);
    case (m)
      2'b00:   return 2'b00;
      2'b01:   return 2'b10;
      2'b10:   return {ph, ~ph};
      default: return p ? 2'b00 : (t ? 2'b01 : {ph, 1'b0});
    endcase
  endfunction

  task automatic test_reset();
    led_mode = 4'b0101;
    rst_n = 1'b0;
    repeat (2) tick();
    vectors++;
    if ({need_write_reg_o, need_read_reg_i, need_read_reg_o, sfp_gled, sfp_rled, timeout_err, cur_ch, sweep_done} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%b required=0", {need_write_reg_o, need_read_reg_i, need_read_reg_o, sfp_gled, sfp_rled, timeout_err, cur_ch, sweep_done});
    end
    rst_n = 1'b1;
    ev_code.delete();
    repeat (40) tick();
    vectors++;
    if (ev_code.size() != 0) begin
      errors++;
      $display("FAIL idle_no_request got=%0d requests required=0", ev_code.size());
    end
    vectors++;
    if (sfp_gled !== 2'b11 || sfp_rled !== 2'b00) begin
      errors++;
      $display("FAIL led_green got=g%b r%b required=g11 r00", sfp_gled, sfp_rled);
    end
    led_mode = 4'b0000;
  endtask

  task automatic test_sweep();
    logic [1:0] mask;
    int ch, kp;
    do_reset();
    for (int it = 0; it < 10; it++) begin
      mask = (it == 0) ? 2'b11 : (it == 1) ? 2'b10 : 2'($urandom_range(1, 3));
      for (int c = 0; c < 2; c++)
        for (int k = 0; k < 3; k++) dly[c][k] = (it < 2) ? 3 : int'($urandom_range(1, 6));
      build_exp(mask);
      run_sweep(mask);
      vectors++;
      if (ev_code.size() != exp_code.size()) begin
        errors++;
        $display("FAIL sweep_len it=%0d got=%0d required=%0d", it, ev_code.size(), exp_code.size());
      end else
        for (int i = 0; i < exp_code.size(); i++) begin
          vectors++;
          if (ev_code[i] !== exp_code[i]) begin
            errors++;
            $display("FAIL sweep_order it=%0d idx=%0d got=%0d required=%0d", it, i, ev_code[i], exp_code[i]);
          end
        end
      for (int i = 0; i < ev_code.size(); i++) begin
        vectors++;
        if (ev_cur[i] !== ev_code[i] % 2) begin
          errors++;
          $display("FAIL cur_ch it=%0d idx=%0d got=%0d required=%0d", it, i, ev_cur[i], ev_code[i] % 2);
        end
        if (i > 0 && ev_code[i] % 2 == ev_code[i-1] % 2 && ev_code[i] / 2 > 0) begin
          ch = ev_code[i] % 2;
          kp = ev_code[i-1] / 2;
          vectors++;
          if (ev_cyc[i] - ev_cyc[i-1] < dly[ch][kp] + RT) begin
            errors++;
            $display("FAIL relax_gap it=%0d idx=%0d got=%0d required>=%0d", it, i, ev_cyc[i] - ev_cyc[i-1], dly[ch][kp] + RT);
          end
        end
      end
      if (ev_code.size() > 0) begin
        vectors++;
        if (ev_cyc[0] - sweep_start < BP + 1) begin
          errors++;
          $display("FAIL wait_timer it=%0d got=%0d required>=%0d", it, ev_cyc[0] - sweep_start, BP + 1);
        end
      end
      vectors++;
      if (timeout_err !== 2'b00) begin
        errors++;
        $display("FAIL no_timeout it=%0d got=%b required=00", it, timeout_err);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    set_dly(3);
    dly[1][0] = -1;
    build_exp(2'b11);
    run_sweep(2'b11);
    vectors++;
    if (ev_code.size() != exp_code.size()) begin
      errors++;
      $display("FAIL stuck_len got=%0d required=%0d", ev_code.size(), exp_code.size());
    end else
      for (int i = 0; i < exp_code.size(); i++) begin
        vectors++;
        if (ev_code[i] !== exp_code[i]) begin
          errors++;
          $display("FAIL stuck_order idx=%0d got=%0d required=%0d", i, ev_code[i], exp_code[i]);
        end
      end
    vectors++;
    if (timeout_err !== exp_err) begin
      errors++;
      $display("FAIL stuck_err got=%b required=%b", timeout_err, exp_err);
    end
    if (ev_code.size() == 4) begin
      vectors++;
      if (err_cyc - ev_cyc[3] < TO || err_cyc - ev_cyc[3] > TO + 2) begin
        errors++;
        $display("FAIL stuck_err_time got=%0d required=%0d..%0d", err_cyc - ev_cyc[3], TO, TO + 2);
      end
    end
    dev_ready[1] = 1'b1;
    dly[1][0] = 3;
    run_sweep(2'b11);
    vectors++;
    if (ev_code.size() != 6 || ev_code[0] !== 0) begin
      errors++;
      $display("FAIL after_timeout got=%0d events required=6 starting with write_o ch0", ev_code.size());
    end
    vectors++;
    if (timeout_err !== 2'b10) begin
      errors++;
      $display("FAIL err_sticky got=%b required=10", timeout_err);
    end
  endtask

  task automatic test_tie();
    for (int t = 0; t < 2; t++) begin
      do_reset();
      set_dly(3);
      dly[0][2] = TO + t;
      build_exp(2'b01);
      run_sweep(2'b01);
      vectors++;
      if (ev_code.size() != 3) begin
        errors++;
        $display("FAIL tie_len t=%0d got=%0d required=3", t, ev_code.size());
      end
      vectors++;
      if (timeout_err !== exp_err) begin
        errors++;
        $display("FAIL tie_err t=%0d got=%b required=%b", t, timeout_err, exp_err);
      end
    end
  endtask

  task automatic test_led();
    logic [1:0] e;
    do_reset();
    set_dly(3);
    led_mode = 4'b0011;
    sfp_prsn = 2'b10;
    sfp_txflt = 2'b01;
    tick();
    vectors++;
    if (sfp_rled[0] !== 1'b1 || sfp_gled[0] !== 1'b0) begin
      errors++;
      $display("FAIL led_txflt got=g%b r%b required=g0 r1", sfp_gled[0], sfp_rled[0]);
    end
    sfp_txflt = 2'b00;
    for (int s = 0; s < 3; s++) begin
      if (s > 0) run_sweep(2'b01);
      tick();
      vectors++;
      if (sfp_gled[0] !== model_phase || sfp_rled[0] !== 1'b0) begin
        errors++;
        $display("FAIL led_phase sweep=%0d got=g%b r%b required=g%b r0", s, sfp_gled[0], sfp_rled[0], model_phase);
      end
    end
    for (int it = 0; it < 16; it++) begin
      if (it % 4 == 3) run_sweep(2'b01);
      led_mode = 4'($urandom);
      sfp_prsn = 2'($urandom);
      sfp_txflt = 2'($urandom);
      tick();
      for (int c = 0; c < 2; c++) begin
        e = led_exp(led_mode[2*c +: 2], model_phase, sfp_prsn[c], sfp_txflt[c]);
        vectors++;
        if ({sfp_gled[c], sfp_rled[c]} !== e) begin
          errors++;
          $display("FAIL led_rand it=%0d ch=%0d mode=%b got=%b required=%b", it, c, led_mode[2*c +: 2], {sfp_gled[c], sfp_rled[c]}, e);
        end
      end
    end
    led_mode = 4'b0000;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    set_dly(3);
    led_mode = 4'b0101;
    ev_code.delete();
    ev_cyc.delete();
    ch_en = 2'b01;
    enable = 1'b1;
    while (!(ev_code.size() > 0 && ev_code[ev_code.size()-1] == 2) && n < 500) begin
      tick();
      n++;
    end
    enable = 1'b0;
    vectors++;
    if (n >= 500) begin
      errors++;
      $display("FAIL reach_read_i got=none required=read_i ch0 within 500 cycles");
    end
    tick();
    rst_n = 1'b0;
    for (int r = 0; r < 2; r++) begin
      if (r == 0) #1;
      else tick();
      vectors++;
      if ({need_write_reg_o, need_read_reg_i, need_read_reg_o, sfp_gled, sfp_rled, timeout_err, cur_ch, sweep_done} !== 14'd0) begin
        errors++;
        $display("FAIL reset_mid step=%0d got=%b required=0", r, {need_write_reg_o, need_read_reg_i, need_read_reg_o, sfp_gled, sfp_rled, timeout_err, cur_ch, sweep_done});
      end
    end
    dev_ready = '1;
    rsp_left[0] = 0;
    rsp_left[1] = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    model_phase = 1'b1;
    tick();
    build_exp(2'b01);
    run_sweep(2'b01);
    vectors++;
    if (ev_code.size() != 3 || ev_code[0] !== 0) begin
      errors++;
      $display("FAIL post_reset got=%0d events required=3 starting with write_o ch0", ev_code.size());
    end else begin
      vectors++;
      if (ev_cyc[0] - sweep_start < BP + 1) begin
        errors++;
        $display("FAIL post_reset_wait got=%0d required>=%0d", ev_cyc[0] - sweep_start, BP + 1);
      end
    end
    led_mode = 4'b0000;
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_dly(3);
    rsp_left[0] = 0;
    rsp_left[1] = 0;
    test_reset();
    test_sweep();
    test_timeout();
    test_tie();
    test_led();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
